// File: rtl/life_engine.sv
// Game of Life generation engine: a ROWS x COLS flop grid, scanned one cell per
// clock into a shadow grid and committed in one cycle. The read port always
// shows the last committed generation.
module life_engine #(
  parameter int         COLS         = 20,
  parameter int         ROWS         = 15,
  parameter int         XW           = 5,
  parameter int         YW           = 4,
  parameter int         WRAP         = 0,
  parameter logic [8:0] BIRTH_MASK   = 9'b000001000,
  parameter logic [8:0] SURVIVE_MASK = 9'b000001100
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          step,
  output logic          busy,
  output logic          done,
  output logic [15:0]   gen_count,
  output logic [15:0]   population,
  input  logic          wr_en,
  input  logic [XW-1:0] wr_x,
  input  logic [YW-1:0] wr_y,
  input  logic          wr_data,
  input  logic [XW-1:0] rd_x,
  input  logic [YW-1:0] rd_y,
  output logic          rd_cell
);

  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

  localparam logic [XW-1:0] XMAX = XW'(COLS - 1);
  localparam logic [YW-1:0] YMAX = YW'(ROWS - 1);

  state_t                   state_q, state_d;
  logic [ROWS-1:0][COLS-1:0] cur_q, cur_d;
  logic [ROWS-1:0][COLS-1:0] nxt_q, nxt_d;
  logic [XW-1:0]            x_q, x_d;
  logic [YW-1:0]            y_q, y_d;
  logic [15:0]              acc_q, acc_d;
  logic [15:0]              gen_q, gen_d;
  logic [15:0]              pop_q, pop_d;
  logic                     rd_q, rd_d;

  // neighbour coordinates, edge validity and the rule lookup for cell (x_q, y_q)
  logic [XW-1:0] xl, xr;
  logic [YW-1:0] yu, yd;
  logic          xl_ok, xr_ok, yu_ok, yd_ok;
  logic [7:0]    nb;
  logic [3:0]    sum;
  logic          self_cell, new_cell;

  // Neighbour count: with WRAP=0 off-grid neighbours are masked to dead,
  // with WRAP=1 the wrapped coordinate is used instead.
  always_comb begin
    xl    = (x_q == '0)   ? XMAX : x_q - XW'(1);
    xr    = (x_q == XMAX) ? '0   : x_q + XW'(1);
    yu    = (y_q == '0)   ? YMAX : y_q - YW'(1);
    yd    = (y_q == YMAX) ? '0   : y_q + YW'(1);
    xl_ok = (x_q != '0)   || (WRAP != 0);
    xr_ok = (x_q != XMAX) || (WRAP != 0);
    yu_ok = (y_q != '0)   || (WRAP != 0);
    yd_ok = (y_q != YMAX) || (WRAP != 0);
    nb[0] = yu_ok & xl_ok & cur_q[yu][xl];
    nb[1] = yu_ok &         cur_q[yu][x_q];
    nb[2] = yu_ok & xr_ok & cur_q[yu][xr];
    nb[3] =         xl_ok & cur_q[y_q][xl];
    nb[4] =         xr_ok & cur_q[y_q][xr];
    nb[5] = yd_ok & xl_ok & cur_q[yd][xl];
    nb[6] = yd_ok &         cur_q[yd][x_q];
    nb[7] = yd_ok & xr_ok & cur_q[yd][xr];
    sum = '0;
    for (int i = 0; i < 8; i++) sum = sum + 4'(nb[i]);
    self_cell = cur_q[y_q][x_q];
    new_cell  = self_cell ? SURVIVE_MASK[sum] : BIRTH_MASK[sum];
  end

  // Next-state logic: FSM, seed writes, scan into nxt, commit into cur.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    nxt_d   = nxt_q;
    x_d     = x_q;
    y_d     = y_q;
    acc_d   = acc_q;
    gen_d   = gen_q;
    pop_d   = pop_q;
    busy    = (state_q != IDLE);
    done    = (state_q == COMMIT);
    // read port shows cur in every state; off-grid reads are 0
    rd_d    = 1'b0;
    if ((32'(rd_x) < COLS) && (32'(rd_y) < ROWS)) rd_d = cur_q[rd_y][rd_x];

    unique case (state_q)
      IDLE: begin
        // the write lands before the scan begins, so a same-edge step sees it
        if (wr_en && (32'(wr_x) < COLS) && (32'(wr_y) < ROWS))
          cur_d[wr_y][wr_x] = wr_data;
        if (step) begin
          state_d = SCAN;
          x_d     = '0;
          y_d     = '0;
          acc_d   = '0;
        end
      end
      SCAN: begin
        nxt_d[y_q][x_q] = new_cell;
        acc_d           = acc_q + 16'(new_cell);
        if (x_q == XMAX) begin
          x_d = '0;
          if (y_q == YMAX) state_d = COMMIT;
          else             y_d     = y_q + YW'(1);
        end else begin
          x_d = x_q + XW'(1);
        end
      end
      COMMIT: begin
        cur_d   = nxt_q;
        pop_d   = acc_q;
        gen_d   = gen_q + 16'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous clear; clear mid-scan discards the generation.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      cur_q   <= '0;
      nxt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      acc_q   <= '0;
      gen_q   <= '0;
      pop_q   <= '0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      nxt_q   <= nxt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      acc_q   <= acc_d;
      gen_q   <= gen_d;
      pop_q   <= pop_d;
      rd_q    <= rd_d;
    end
  end

  assign gen_count  = gen_q;
  assign population = pop_q;
  assign rd_cell    = rd_q;

endmodule

// File: tb/tb_life_engine.sv
// Directed bench for life_engine: two instances (dead edges and toroidal) share
// all inputs; expected grids and counts are hand-computed.
module tb_life_engine;
  localparam int COLS = 20;
  localparam int ROWS = 15;

  logic       clk = 1'b0;
  logic       clr, step, wr_en, wr_data;
  logic [4:0] wr_x, rd_x;
  logic [3:0] wr_y, rd_y;
  logic        busy0, done0, rd0, busy1, done1, rd1;
  logic [15:0] gen0, pop0, gen1, pop1;

  int checks = 0;
  int errors = 0;
  logic [ROWS-1:0][COLS-1:0] exp_g;

  typedef struct {
    int   x;
    int   y;
    logic e;
  } rd_vec_t;
  rd_vec_t rd_tab[8];

  life_engine #(.WRAP(0)) u_dut0 (
    .clk(clk), .clr(clr), .step(step), .busy(busy0), .done(done0),
    .gen_count(gen0), .population(pop0), .wr_en(wr_en), .wr_x(wr_x),
    .wr_y(wr_y), .wr_data(wr_data), .rd_x(rd_x), .rd_y(rd_y), .rd_cell(rd0)
  );

  life_engine #(.WRAP(1)) u_dut1 (
    .clk(clk), .clr(clr), .step(step), .busy(busy1), .done(done1),
    .gen_count(gen1), .population(pop1), .wr_en(wr_en), .wr_x(wr_x),
    .wr_y(wr_y), .wr_data(wr_data), .rd_x(rd_x), .rd_y(rd_y), .rd_cell(rd1)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic wr(input int x, input int y, input logic v);
    wr_en = 1'b1; wr_x = 5'(x); wr_y = 4'(y); wr_data = v;
    tick;
    wr_en = 1'b0;
  endtask

  task automatic do_reset;
    clr = 1'b1;
    tick;
    clr = 1'b0;
  endtask

  // ticks until done is seen on the dead-edge instance, bounded
  task automatic wait_done(output int n);
    n = 0;
    while (done0 !== 1'b1 && n < 400) begin
      tick;
      n++;
    end
  endtask

  // one full generation: step edge, scan, commit edge; returns step-to-done latency
  task automatic gen_step(output int lat);
    step = 1'b1;
    tick;
    step = 1'b0;
    wait_done(lat);
    tick;
  endtask

  task automatic check_grid(input string nm, input bit w);
    int mism;
    logic got;
    mism = 0;
    for (int y = 0; y < ROWS; y++)
      for (int x = 0; x < COLS; x++) begin
        rd_x = 5'(x); rd_y = 4'(y);
        tick;
        got = w ? rd1 : rd0;
        if (got !== exp_g[y][x]) mism++;
      end
    check(nm, mism, 0);
  endtask

  task automatic seed_blinker;
    wr(5, 7, 1'b1); wr(6, 7, 1'b1); wr(7, 7, 1'b1);
  endtask

  task automatic exp_vertical;
    exp_g = '0; exp_g[6][6] = 1'b1; exp_g[7][6] = 1'b1; exp_g[8][6] = 1'b1;
  endtask

  initial begin
    int n, busy_cnt, done_cnt, guard;
    clr = 1'b1; step = 1'b0; wr_en = 1'b0; wr_x = '0; wr_y = '0; wr_data = 1'b0;
    rd_x = '0; rd_y = '0;

    // read-port vectors after the first blinker generation (vertical bar)
    rd_tab[0] = '{6, 6, 1'b1};
    rd_tab[1] = '{6, 7, 1'b1};
    rd_tab[2] = '{6, 8, 1'b1};
    rd_tab[3] = '{5, 7, 1'b0};
    rd_tab[4] = '{7, 7, 1'b0};
    rd_tab[5] = '{20, 7, 1'b0};
    rd_tab[6] = '{5, 15, 1'b0};
    rd_tab[7] = '{31, 14, 1'b0};

    // reset state
    tick;
    clr = 1'b0;
    check("rst_busy", int'(busy0), 0);
    check("rst_done", int'(done0), 0);
    check("rst_gen", int'(gen0), 0);
    check("rst_pop", int'(pop0), 0);
    check("rst_rd", int'(rd0), 0);

    // blinker, with off-grid writes that must be ignored
    seed_blinker;
    wr(20, 7, 1'b1);
    wr(5, 15, 1'b1);
    check("pop_not_by_write", int'(pop0), 0);
    rd_x = 5'd6; rd_y = 4'd7;
    step = 1'b1;
    tick;
    step = 1'b0;
    check("busy_after_step", int'(busy0), 1);
    tick;
    check("rd_old_gen_in_scan", int'(rd0), 1);
    rd_x = 5'd20; rd_y = 4'd0;
    tick;
    check("rd_oob_in_scan", int'(rd0), 0);
    wait_done(n);
    check("blinker_done_lat", n + 2, 300);
    check("busy_in_commit", int'(busy0), 1);
    rd_x = 5'd6; rd_y = 4'd6;
    tick;
    check("done_one_cycle", int'(done0), 0);
    check("busy_after_commit", int'(busy0), 0);
    check("blinker_gen1", int'(gen0), 1);
    check("blinker_pop1", int'(pop0), 3);
    tick;
    check("rd_new_gen_k302", int'(rd0), 1);
    foreach (rd_tab[i]) begin
      rd_x = 5'(rd_tab[i].x); rd_y = 4'(rd_tab[i].y);
      tick;
      check($sformatf("rd_tab%0d", i), int'(rd0), int'(rd_tab[i].e));
    end
    exp_vertical;
    check_grid("blinker_g1_grid", 1'b0);
    gen_step(n);
    check("blinker_gen2", int'(gen0), 2);
    check("blinker_pop2", int'(pop0), 3);
    exp_g = '0; exp_g[7][5] = 1'b1; exp_g[7][6] = 1'b1; exp_g[7][7] = 1'b1;
    check_grid("blinker_g2_grid", 1'b0);

    // block still life over five generations
    do_reset;
    wr(3, 3, 1'b1); wr(4, 3, 1'b1); wr(3, 4, 1'b1); wr(4, 4, 1'b1);
    for (int g = 0; g < 5; g++) gen_step(n);
    check("block_gen5", int'(gen0), 5);
    check("block_pop", int'(pop0), 4);
    exp_g = '0; exp_g[3][3] = 1'b1; exp_g[3][4] = 1'b1; exp_g[4][3] = 1'b1; exp_g[4][4] = 1'b1;
    check_grid("block_grid", 1'b0);

    // edge mode: bar along the top row
    do_reset;
    wr(0, 0, 1'b1); wr(1, 0, 1'b1); wr(2, 0, 1'b1);
    gen_step(n);
    check("edge_pop_dead", int'(pop0), 2);
    check("edge_pop_wrap", int'(pop1), 3);
    exp_g = '0; exp_g[0][1] = 1'b1; exp_g[1][1] = 1'b1;
    check_grid("edge_grid_dead", 1'b0);
    exp_g[14][1] = 1'b1;
    check_grid("edge_grid_wrap", 1'b1);

    // handshake: step held 3 cycles, step and write pulsed mid-scan
    do_reset;
    seed_blinker;
    busy_cnt = 0; done_cnt = 0; guard = 0;
    step = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      busy_cnt += int'(busy0);
      done_cnt += int'(done0);
    end
    step = 1'b0;
    while (busy0 && guard < 400) begin
      if (guard == 150) begin
        step = 1'b1; wr_en = 1'b1; wr_x = 5'd0; wr_y = 4'd0; wr_data = 1'b1;
      end
      tick;
      step = 1'b0; wr_en = 1'b0;
      busy_cnt += int'(busy0);
      done_cnt += int'(done0);
      guard++;
    end
    check("hs_busy_cycles", busy_cnt, 301);
    check("hs_done_pulses", done_cnt, 1);
    repeat (5) tick;
    check("hs_not_queued_busy", int'(busy0), 0);
    check("hs_gen", int'(gen0), 1);
    exp_vertical;
    check_grid("hs_grid_write_dropped", 1'b0);

    // clear in the middle of a scan
    do_reset;
    seed_blinker;
    gen_step(n);
    check("pre_clr_gen", int'(gen0), 1);
    step = 1'b1;
    tick;
    step = 1'b0;
    repeat (100) tick;
    clr = 1'b1;
    tick;
    clr = 1'b0;
    check("clr_busy", int'(busy0), 0);
    check("clr_done", int'(done0), 0);
    check("clr_gen", int'(gen0), 0);
    check("clr_pop", int'(pop0), 0);
    check("clr_rd", int'(rd0), 0);
    exp_g = '0;
    check_grid("clr_grid", 1'b0);
    done_cnt = 0;
    for (int i = 0; i < 310; i++) begin
      tick;
      done_cnt += int'(done0);
    end
    check("clr_no_done", done_cnt, 0);
    check("clr_gen_after", int'(gen0), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
